// File: rtl/lanzones_imem_responder.sv
// Instruction-memory responder for the lanzones core: host preload port plus valid/ready fetch port.
// Optional fetch wait states are enabled by defining LANZONES_IMEM_WAIT_EN (latency WAIT_CYCLES+1).
module lanzones_imem_responder #(
  parameter int unsigned AW       = 5,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
`ifdef LANZONES_IMEM_WAIT_EN
  ,
  parameter int unsigned WAIT_CYCLES = 2
`endif
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic [AW:0]   ld_count,
  output logic          ld_err,
  output logic          LEn,
  input  logic          RRdy,
  input  logic [31:0]   RAddr,
  output logic          RVld,
  output logic [31:0]   RData,
  output logic          rd_err
);

  localparam int unsigned DEPTH     = 2 ** AW;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] mem [DEPTH];

  logic        ld_fire;
  logic        ld_in_range;
  logic [31:0] fetch_addr;
  logic        fetch_in_range;
  logic        rdata_load;

  // Handshake outputs are pure state decodes, so they follow reset and state changes exactly.
  assign ld_ready    = (state == S_LOAD);
  assign LEn         = (state != S_LOAD);
  assign RVld        = (state == S_VALID);

  assign ld_fire     = ld_valid & ld_ready;
  assign ld_in_range = (ld_addr[31:AW] == '0);

`ifdef LANZONES_IMEM_WAIT_EN
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;

  // The address is frozen in S_IDLE; the array is read when the wait counter expires.
  assign fetch_addr = addr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wait_cnt <= '0;
      addr_q   <= '0;
    end else if (state == S_IDLE && RRdy) begin
      wait_cnt <= 4'(WAIT_CYCLES);
      addr_q   <= RAddr;
    end else if (state == S_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end
`else
  assign fetch_addr = RAddr;
`endif

  assign fetch_in_range = (fetch_addr[31:AW] == '0);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    rdata_load = 1'b0;
    unique case (state)
      S_LOAD: begin
        if (ld_fire && ld_last) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (RRdy) begin
`ifdef LANZONES_IMEM_WAIT_EN
          state_nxt  = S_WAIT;
`else
          state_nxt  = S_VALID;
          rdata_load = 1'b1;
`endif
        end
      end
`ifdef LANZONES_IMEM_WAIT_EN
      S_WAIT: begin
        // Leaving while the counter steps 1->0 gives WAIT_CYCLES cycles in S_WAIT.
        if (wait_cnt <= 4'd1) begin
          state_nxt  = S_VALID;
          rdata_load = 1'b1;
        end
      end
`endif
      S_VALID: begin
        if (RRdy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset here is synchronous to clk.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_LOAD;
      ld_count <= '0;
      ld_err   <= 1'b0;
      RData    <= '0;
      rd_err   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ld_err <= ld_fire && !ld_in_range;
      if (ld_fire && ld_in_range && ld_count != DEPTH_CNT) begin
        ld_count <= ld_count + 1'b1;
      end
      if (rdata_load) begin
        RData <= fetch_in_range ? mem[fetch_addr[AW-1:0]] : NOP_WORD;
        if (!fetch_in_range) rd_err <= 1'b1;
      end
    end
  end

  // NOTE: the array has no reset so the preloaded image survives rstn and maps to plain RAM.
  always_ff @(posedge clk) begin
    if (ld_fire && ld_in_range) begin
      mem[ld_addr[AW-1:0]] <= ld_data;
    end
  end

endmodule
